time_sync_ctrl: RTL
===================

# time_sync_ctrl

System-clock controller that receives the 32-bit time frame from the PIC over the SPI link (sclk/sdi, MSB first, no chip select). It synchronises the link into `clk`, frames and validates each word, and loads a free-running local calendar clock. Between syncs the clock advances once per second, so the VGA display always has a live time and date.

## Interface
- `CLK_HZ`, 25_000_000, `clk` cycles per second tick (≥2).
- `GAP_CYC`, 4096, idle `clk` cycles after which a partial frame is discarded.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `sclk` in 1: raw SPI clock from the PIC, asynchronous to `clk`.
- `sdi` in 1: raw SPI data, valid on `sclk` rise.
- `header` out 1: bit 31 of the last accepted frame (1 = PIC currently syncing).
- `year` out 5: years since 2000, 0–31.
- `month` out 4: 1–12.
- `day` out 5: 1–31.
- `hour` out 5: 0–23.
- `minute`, `second` out 6: 0–59.
- `frame_ok` out 1: one-cycle pulse on each accepted load.
- `err_cnt` out 8: rejected-frame count, saturating at 255.
- `sync_age` out 16: seconds since the last accepted load (see Configuration).

## Operation
- `sclk` and `sdi` each pass through a 2-FF synchroniser. A rising-edge detect on the synchronised `sclk` shifts the synchronised `sdi` into a 32-bit register: `sr <= {sr[30:0], sdi}`.
- Frame field layout: [31] header, [30:26] year, [25:22] month, [21:17] day, [16:12] hour, [11:6] minute, [5:0] second.
- FSM states:
  - IDLE: no bits yet. The first edge captures bit 0 and moves to SHIFT.
  - SHIFT: each edge increments the 5-bit bit counter. The edge that captures bit 31 moves to CHECK. If `GAP_CYC` cycles pass with no edge, the counter clears and the FSM returns to IDLE with no error counted.
  - CHECK: one cycle. A frame is valid iff month 1–12, day 1–`dim(month,year)`, hour ≤23, minute ≤59 and second ≤59. Valid goes to LOAD. Invalid increments `err_cnt` (saturating) and returns to IDLE.
  - LOAD: one cycle. Copies all fields into the time registers, clears the prescaler, clears `sync_age`, pulses `frame_ok`, then returns to IDLE.
- Month lengths `dim`: 31/30 per the calendar. February is 29 when `year[1:0]==0`, otherwise 28.
- Prescaler counts 0..`CLK_HZ`-1. On wrap it issues a one-cycle tick.
- Tick cascade:
  - second 59→0 carries into minute.
  - minute 59→0 carries into hour.
  - hour 23→0 carries into day.
  - day `dim`→1 carries into month.
  - month 12→1 carries into year.
  - year 31→0 (wrap, no flag).
- Edges arriving during CHECK or LOAD are captured as bit 0 of the next frame; no bit is lost.
- Reset values:
  - year 0, month 1, day 1, hour 0, minute 0, second 0.
  - `header` 0, `frame_ok` 0, `err_cnt` 0, `sync_age` 0.
  - FSM IDLE; shift register, bit counter, gap counter and prescaler 0.

## Timing
- `sclk` high and low phases must each be ≥3 `clk` periods; this is the supported limit.
- Capture point: the cycle cycle C is the one in which bit 31 is captured (3 cycles after the `sclk` pin rise).
  - C+1: CHECK.
  - C+2: LOAD is active; new values appear on the outputs and `frame_ok` is high from the C+2 clock edge.
  - An invalid frame updates `err_cnt` at C+2.
- Tick coinciding with LOAD: LOAD wins, the tick is dropped, and the prescaler restarts at 0.
- Reset mid-frame: asynchronous clear of all state. The partial frame is lost and the next frame must start from bit 0.
- Gap timeout is measured from the last synchronised edge. At exactly `GAP_CYC` idle cycles the frame is discarded.

## Configuration
- `TIME_SYNC_AGE_EN` defined:
  - `sync_age` increments on every tick and saturates at 16'hFFFF.
  - It clears on LOAD and on reset.
- Not defined: `sync_age` is tied to 0 and its counter logic is not built.

## Test plan
- Valid frame: reset, then shift 32'h0A4A_B5E4 → at C+2 `header`=0, year 2, month 9, day 5, hour 11, minute 23, second 36, `frame_ok` one cycle, `err_cnt` 0.
- Rollover: load 2000-02-28 23:59:59 with `CLK_HZ`=8 → after 8 cycles the date is 02-29 00:00:00. Load year 1, same date → 03-01 00:00:00.
- Invalid frame: month 13 → outputs unchanged, `err_cnt` 1, no `frame_ok`. Then 256 further invalid frames → `err_cnt` stays 255.
- Gap recovery: send 20 bits, idle `GAP_CYC` cycles, then a full valid frame → only the full frame loads, `err_cnt` 0.
- Collision: time LOAD to coincide with a prescaler wrap → loaded seconds are not incremented and the next tick arrives `CLK_HZ` cycles later. Also assert `reset_n` low at bit 16 → all outputs take their reset values immediately.
- With `TIME_SYNC_AGE_EN`: 5 ticks after a load → `sync_age`=5. Without the macro → `sync_age` stays 0.

Source files
------------

// File: rtl/time_sync_ctrl.sv
// time_sync_ctrl: frames the PIC's 32-bit SPI time word and keeps a free-running calendar clock.
// Build macro TIME_SYNC_AGE_EN adds the seconds-since-last-sync counter on sync_age.

module time_sync_ctrl #(
    parameter int CLK_HZ  = 25_000_000,
    parameter int GAP_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sclk,
    input  logic        sdi,
    output logic        header,
    output logic [4:0]  year,
    output logic [3:0]  month,
    output logic [4:0]  day,
    output logic [4:0]  hour,
    output logic [5:0]  minute,
    output logic [5:0]  second,
    output logic        frame_ok,
    output logic [7:0]  err_cnt,
    output logic [15:0] sync_age
);
    // state | meaning
    // IDLE  | no bits of a frame captured yet
    // SHIFT | collecting bits 1..31, gap timer running
    // CHECK | validating the captured word
    // LOAD  | calendar just loaded, frame_ok high
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_LOAD} state_t;

    localparam int PW = $clog2(CLK_HZ);
    localparam int GW = $clog2(GAP_CYC);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYC - 1);

    state_t        r_state, w_state_nxt;
    logic          r_sclk_meta, r_sclk_sync, r_sclk_prev, r_sdi_meta, r_sdi_sync;
    logic [31:0]   r_sr;
    logic [4:0]    r_bit_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic [PW-1:0] r_pre;
    logic          r_header;
    logic [4:0]    r_year, r_day, r_hour;
    logic [3:0]    r_month;
    logic [5:0]    r_minute, r_second;
    logic [7:0]    r_err;
    logic          w_rise, w_valid, w_load, w_reject, w_tick;
    logic [4:0]    w_dim_frame, w_dim_now;

    function automatic logic [4:0] f_dim(input logic [3:0] mon, input logic [4:0] yr);
        case (mon)
            4'd2:                      f_dim = (yr[1:0] == 2'd0) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   f_dim = 5'd30;
            default:                   f_dim = 5'd31;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_sdi_meta  <= 1'b0;
            r_sdi_sync  <= 1'b0;
        end else begin
            r_sclk_meta <= sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_sdi_meta  <= sdi;
            r_sdi_sync  <= r_sdi_meta;
        end
    end

    assign w_rise      = r_sclk_sync & ~r_sclk_prev;
    assign w_dim_frame = f_dim(r_sr[25:22], r_sr[30:26]);
    assign w_dim_now   = f_dim(r_month, r_year);
    assign w_valid     = (r_sr[25:22] >= 4'd1) && (r_sr[25:22] <= 4'd12) &&
                         (r_sr[21:17] >= 5'd1) && (r_sr[21:17] <= w_dim_frame) &&
                         (r_sr[16:12] <= 5'd23) && (r_sr[11:6] <= 6'd59) && (r_sr[5:0] <= 6'd59);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_rise && r_bit_cnt == 5'd31)           w_state_nxt = S_CHECK;
                else if (!w_rise && r_gap_cnt == GAP_MAX)   w_state_nxt = S_IDLE;
            end
            S_CHECK: begin
                if (w_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_reject    = 1'b1;
                    w_state_nxt = w_rise ? S_SHIFT : S_IDLE;
                end
            end
            S_LOAD:  w_state_nxt = (w_rise || r_bit_cnt != 5'd0) ? S_SHIFT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // An edge seen in CHECK/LOAD becomes bit 0 of the next frame; the counter is already 0 there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_err     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rise) begin
                r_sr      <= {r_sr[30:0], r_sdi_sync};
                r_bit_cnt <= r_bit_cnt + 5'd1;
                r_gap_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                if (r_gap_cnt == GAP_MAX) begin
                    r_gap_cnt <= '0;
                    r_bit_cnt <= '0;
                end else begin
                    r_gap_cnt <= r_gap_cnt + GW'(1);
                end
            end else begin
                r_gap_cnt <= '0;
            end
            if (w_reject && r_err != 8'hFF) r_err <= r_err + 8'd1;
        end
    end

    assign w_tick = (r_pre == PRE_MAX) && !w_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre    <= '0;
            r_header <= 1'b0;
            r_year   <= 5'd0;
            r_month  <= 4'd1;
            r_day    <= 5'd1;
            r_hour   <= 5'd0;
            r_minute <= 6'd0;
            r_second <= 6'd0;
        end else if (w_load) begin
            r_pre    <= '0;
            r_header <= r_sr[31];
            r_year   <= r_sr[30:26];
            r_month  <= r_sr[25:22];
            r_day    <= r_sr[21:17];
            r_hour   <= r_sr[16:12];
            r_minute <= r_sr[11:6];
            r_second <= r_sr[5:0];
        end else begin
            r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + PW'(1);
            if (w_tick) begin
                if (r_second != 6'd59) r_second <= r_second + 6'd1;
                else begin
                    r_second <= 6'd0;
                    if (r_minute != 6'd59) r_minute <= r_minute + 6'd1;
                    else begin
                        r_minute <= 6'd0;
                        if (r_hour != 5'd23) r_hour <= r_hour + 5'd1;
                        else begin
                            r_hour <= 5'd0;
                            if (r_day != w_dim_now) r_day <= r_day + 5'd1;
                            else begin
                                r_day <= 5'd1;
                                if (r_month != 4'd12) r_month <= r_month + 4'd1;
                                else begin
                                    r_month <= 4'd1;
                                    r_year  <= r_year + 5'd1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

`ifdef TIME_SYNC_AGE_EN
    logic [15:0] r_age;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         r_age <= '0;
        else if (w_load)                      r_age <= '0;
        else if (w_tick && r_age != 16'hFFFF) r_age <= r_age + 16'd1;
    end
    assign sync_age = r_age;
`else
    assign sync_age = 16'd0;
`endif

    assign header   = r_header;
    assign year     = r_year;
    assign month    = r_month;
    assign day      = r_day;
    assign hour     = r_hour;
    assign minute   = r_minute;
    assign second   = r_second;
    assign frame_ok = (r_state == S_LOAD);
    assign err_cnt  = r_err;

endmodule
